// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bundle with 32-bit address and data, used by axil_reg_slave.
interface axi_lite;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave: REG_NUM RW control regs, STAT_NUM RO status regs.
// Define AXIL_REG_STICKY_EN to make status registers sticky, clear-on-read latches.
module axil_ctrl_reg #(
  parameter logic [31:0] RST = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [3:0]  strb,
  input  logic [31:0] d,
  output logic [31:0] q,
  output logic        wr
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q  <= RST;
      wr <= 1'b0;
    end else begin
      wr <= we;
      if (we)
        for (int b = 0; b < 4; b++)
          if (strb[b]) q[8*b +: 8] <= d[8*b +: 8];
    end
  end
endmodule

`ifdef AXIL_REG_STICKY_EN
module axil_stat_latch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [31:0] d,
  output logic [31:0] q
);
  // A read returns every latched bit, so clearing drops all of them; d re-sets same-cycle events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= (clr ? 32'h0 : q) | d;
  end
endmodule
`endif

module axil_reg_slave #(
  parameter int ADDR_W   = 12,
  parameter int REG_NUM  = 8,
  parameter int STAT_NUM = 4,
  parameter logic [REG_NUM*32-1:0] RST_VAL = '0
) (
  input  logic                    sys_clk,
  input  logic                    perif_rst_n,
  axi_lite.slave                  s_axil,
  output logic [REG_NUM*32-1:0]   ctrl_reg,
  output logic [REG_NUM-1:0]      ctrl_wr,
  input  logic [STAT_NUM*32-1:0]  stat_in
);
  localparam int IDX_W = ADDR_W - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [31:0]      data;
    logic [3:0]       strb;
  } wr_req_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [IDX_W-1:0] aw_idx, ar_idx, aw_idx_q;
  logic [31:0]      w_data_q;
  logic [3:0]       w_strb_q;
  logic             aw_hs, w_hs, ar_hs;

  wr_req_t          cmt;
  logic             cmt_en, cmt_ok;
  logic [REG_NUM-1:0] ctrl_we;

  logic [REG_NUM-1:0][31:0]  ctrl_q;
  logic [STAT_NUM-1:0][31:0] stat_v, stat_q;
  logic [STAT_NUM-1:0]       stat_clr;
  logic [31:0]               rd_val;
  logic                      rd_ok;

  logic unused;
  assign unused = &{1'b0, s_axil.awaddr, s_axil.araddr, s_axil.awprot, s_axil.arprot, stat_clr};

  assign aw_idx = s_axil.awaddr[ADDR_W-1:2];
  assign ar_idx = s_axil.araddr[ADDR_W-1:2];
  assign aw_hs  = s_axil.awvalid && s_axil.awready;
  assign w_hs   = s_axil.wvalid  && s_axil.wready;
  assign ar_hs  = s_axil.arvalid && s_axil.arready;

  // The commit fires on the second handshake edge, merging live and held channel halves.
  always_comb begin
    cmt_en = 1'b0;
    cmt    = '{idx: aw_idx, data: s_axil.wdata, strb: s_axil.wstrb};
    case (w_state)
      W_IDLE:    cmt_en = aw_hs && w_hs;
      W_HAVE_AW: begin
        cmt_en  = w_hs;
        cmt.idx = aw_idx_q;
      end
      W_HAVE_W:  begin
        cmt_en   = aw_hs;
        cmt.data = w_data_q;
        cmt.strb = w_strb_q;
      end
      default:   cmt_en = 1'b0;
    endcase
  end

  assign cmt_ok = cmt.idx < IDX_W'(REG_NUM);

  for (genvar k = 0; k < REG_NUM; k++) begin : g_ctrl
    assign ctrl_we[k] = cmt_en && (cmt.idx == IDX_W'(k));
    axil_ctrl_reg #(.RST(RST_VAL[32*k +: 32])) u_reg (
      .clk  (sys_clk),
      .rst_n(perif_rst_n),
      .we   (ctrl_we[k]),
      .strb (cmt.strb),
      .d    (cmt.data),
      .q    (ctrl_q[k]),
      .wr   (ctrl_wr[k])
    );
  end

  assign ctrl_reg = ctrl_q;
  assign stat_v   = stat_in;

  for (genvar j = 0; j < STAT_NUM; j++) begin : g_stat
    assign stat_clr[j] = ar_hs && (ar_idx == IDX_W'(REG_NUM + j));
`ifdef AXIL_REG_STICKY_EN
    axil_stat_latch u_lat (
      .clk  (sys_clk),
      .rst_n(perif_rst_n),
      .clr  (stat_clr[j]),
      .d    (stat_v[j]),
      .q    (stat_q[j])
    );
`else
    assign stat_q[j] = stat_v[j];
`endif
  end

  always_ff @(posedge sys_clk or negedge perif_rst_n) begin
    if (!perif_rst_n) begin
      w_state        <= W_IDLE;
      s_axil.awready <= 1'b0;
      s_axil.wready  <= 1'b0;
      s_axil.bvalid  <= 1'b0;
      s_axil.bresp   <= RESP_OKAY;
      aw_idx_q       <= '0;
      w_data_q       <= '0;
      w_strb_q       <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            w_state        <= W_RESP;
            s_axil.awready <= 1'b0;
            s_axil.wready  <= 1'b0;
          end else if (aw_hs) begin
            w_state        <= W_HAVE_AW;
            s_axil.awready <= 1'b0;
            s_axil.wready  <= 1'b1;
            aw_idx_q       <= aw_idx;
          end else if (w_hs) begin
            w_state        <= W_HAVE_W;
            s_axil.awready <= 1'b1;
            s_axil.wready  <= 1'b0;
            w_data_q       <= s_axil.wdata;
            w_strb_q       <= s_axil.wstrb;
          end else begin
            s_axil.awready <= 1'b1;
            s_axil.wready  <= 1'b1;
          end
        end
        W_HAVE_AW: if (w_hs) begin
          w_state       <= W_RESP;
          s_axil.wready <= 1'b0;
        end
        W_HAVE_W: if (aw_hs) begin
          w_state        <= W_RESP;
          s_axil.awready <= 1'b0;
        end
        W_RESP: if (s_axil.bready) begin
          w_state        <= W_IDLE;
          s_axil.bvalid  <= 1'b0;
          s_axil.awready <= 1'b1;
          s_axil.wready  <= 1'b1;
        end
        default: w_state <= W_IDLE;
      endcase
      if (cmt_en) begin
        s_axil.bvalid <= 1'b1;
        s_axil.bresp  <= cmt_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    rd_ok  = 1'b0;
    for (int k = 0; k < REG_NUM; k++)
      if (ar_idx == IDX_W'(k)) begin
        rd_val = ctrl_q[k];
        rd_ok  = 1'b1;
      end
    for (int j = 0; j < STAT_NUM; j++)
      if (ar_idx == IDX_W'(REG_NUM + j)) begin
        rd_val = stat_q[j];
        rd_ok  = 1'b1;
      end
  end

  // rdata samples register state at the AR edge, so a same-edge write is not yet visible.
  always_ff @(posedge sys_clk or negedge perif_rst_n) begin
    if (!perif_rst_n) begin
      r_state        <= R_IDLE;
      s_axil.arready <= 1'b0;
      s_axil.rvalid  <= 1'b0;
      s_axil.rdata   <= '0;
      s_axil.rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state        <= R_DATA;
            s_axil.arready <= 1'b0;
            s_axil.rvalid  <= 1'b1;
            s_axil.rdata   <= rd_val;
            s_axil.rresp   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
          end else begin
            s_axil.arready <= 1'b1;
          end
        end
        R_DATA: if (s_axil.rready) begin
          r_state        <= R_IDLE;
          s_axil.rvalid  <= 1'b0;
          s_axil.arready <= 1'b1;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave: vector table plus hand-written channel-ordering sequences.
module tb_axil_reg_slave;
  localparam int LIM = 20;
  localparam logic [255:0] RST = {32'hC0DE0007, 32'hC0DE0006, 32'hC0DE0005, 32'hC0DE0004,
                                  32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
  localparam logic [127:0] STAT = {32'h5A000003, 32'h5A000002, 32'h5A000001, 32'h5A000000};

  logic         sys_clk, perif_rst_n;
  logic [255:0] ctrl_reg;
  logic [7:0]   ctrl_wr;
  logic [127:0] stat_in;
  axi_lite s_axil();

  axil_reg_slave #(.ADDR_W(12), .REG_NUM(8), .STAT_NUM(4), .RST_VAL(RST)) dut (
    .sys_clk    (sys_clk),
    .perif_rst_n(perif_rst_n),
    .s_axil     (s_axil),
    .ctrl_reg   (ctrl_reg),
    .ctrl_wr    (ctrl_wr),
    .stat_in    (stat_in)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_chk = 0, n_err = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [7:0]  pulse;
  } vec_t;
  vec_t vt[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm, input int n);
    if (n >= LIM) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: timeout after %0d cycles", nm, n);
    end
  endtask

  function automatic logic [31:0] creg(input int k);
    return ctrl_reg[32*k +: 32];
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] r, output logic [7:0] p);
    int n;
    @(negedge sys_clk);
    s_axil.awvalid = 1'b1; s_axil.awaddr = a;
    s_axil.wvalid  = 1'b1; s_axil.wdata  = d; s_axil.wstrb = s;
    n = 0;
    while (!(s_axil.awready && s_axil.wready) && n < LIM) begin @(negedge sys_clk); n++; end
    tmo("wr_ready", n);
    @(negedge sys_clk);
    s_axil.awvalid = 1'b0; s_axil.wvalid = 1'b0;
    p = ctrl_wr;
    n = 0;
    while (!s_axil.bvalid && n < LIM) begin @(negedge sys_clk); n++; end
    tmo("wr_bvalid", n);
    r = s_axil.bresp;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    @(negedge sys_clk);
    s_axil.arvalid = 1'b1; s_axil.araddr = a;
    n = 0;
    while (!s_axil.arready && n < LIM) begin @(negedge sys_clk); n++; end
    tmo("rd_ready", n);
    @(negedge sys_clk);
    s_axil.arvalid = 1'b0;
    n = 0;
    while (!s_axil.rvalid && n < LIM) begin @(negedge sys_clk); n++; end
    tmo("rd_rvalid", n);
    d = s_axil.rdata; r = s_axil.rresp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [7:0]  p;

    vt[0]  = '{0, 32'h000,  32'h0,        4'h0, 2'b00, 32'hC0DE0000, 8'h00};
    vt[1]  = '{0, 32'h01C,  32'h0,        4'h0, 2'b00, 32'hC0DE0007, 8'h00};
    vt[2]  = '{1, 32'h000,  32'h12345678, 4'hF, 2'b00, 32'h0,        8'h01};
    vt[3]  = '{0, 32'h000,  32'h0,        4'h0, 2'b00, 32'h12345678, 8'h00};
    vt[4]  = '{1, 32'h003,  32'hAABBCCDD, 4'h8, 2'b00, 32'h0,        8'h01};
    vt[5]  = '{0, 32'h002,  32'h0,        4'h0, 2'b00, 32'hAA345678, 8'h00};
    vt[6]  = '{1, 32'h008,  32'h00000011, 4'hF, 2'b00, 32'h0,        8'h04};
    vt[7]  = '{1, 32'h010,  32'hFFFFFFFF, 4'h0, 2'b00, 32'h0,        8'h10};
    vt[8]  = '{0, 32'h010,  32'h0,        4'h0, 2'b00, 32'hC0DE0004, 8'h00};
    vt[9]  = '{1, 32'h020,  32'h0000DEAD, 4'hF, 2'b10, 32'h0,        8'h00};
    vt[10] = '{1, 32'h030,  32'h0000BEEF, 4'hF, 2'b10, 32'h0,        8'h00};
    vt[11] = '{0, 32'hFFC,  32'h0,        4'h0, 2'b10, 32'h0,        8'h00};
    vt[12] = '{1, 32'h1004, 32'h5555AAAA, 4'h4, 2'b00, 32'h0,        8'h02};
    vt[13] = '{0, 32'h004,  32'h0,        4'h0, 2'b00, 32'hC0550001, 8'h00};
    vt[14] = '{0, 32'h024,  32'h0,        4'h0, 2'b00, 32'h5A000001, 8'h00};
    vt[15] = '{0, 32'h02C,  32'h0,        4'h0, 2'b00, 32'h5A000003, 8'h00};
    vt[16] = '{0, 32'h020,  32'h0,        4'h0, 2'b00, 32'h5A000000, 8'h00};
    vt[17] = '{0, 32'h030,  32'h0,        4'h0, 2'b10, 32'h0,        8'h00};

    perif_rst_n = 1'b0;
    stat_in = STAT;
    s_axil.awvalid = 1'b0; s_axil.awaddr = '0; s_axil.awprot = 3'b010;
    s_axil.wvalid  = 1'b0; s_axil.wdata  = '0; s_axil.wstrb  = '0;
    s_axil.bready  = 1'b1;
    s_axil.arvalid = 1'b0; s_axil.araddr = '0; s_axil.arprot = 3'b001;
    s_axil.rready  = 1'b1;

    // reset state
    @(negedge sys_clk); @(negedge sys_clk);
    chk("rst_awready", 32'(s_axil.awready), 0);
    chk("rst_wready",  32'(s_axil.wready), 0);
    chk("rst_arready", 32'(s_axil.arready), 0);
    chk("rst_bvalid",  32'(s_axil.bvalid), 0);
    chk("rst_rvalid",  32'(s_axil.rvalid), 0);
    chk("rst_rdata",   s_axil.rdata, 0);
    chk("rst_ctrl_wr", 32'(ctrl_wr), 0);
    for (int k = 0; k < 8; k++) chk($sformatf("rst_reg%0d", k), creg(k), RST[32*k +: 32]);
    perif_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("idle_awready", 32'(s_axil.awready), 1);
    chk("idle_wready",  32'(s_axil.wready), 1);
    chk("idle_arready", 32'(s_axil.arready), 1);

    for (int i = 0; i < 18; i++) begin
      if (vt[i].wr) begin
        wr(vt[i].addr, vt[i].data, vt[i].strb, r, p);
        chk($sformatf("v%0d_bresp", i), 32'(r), 32'(vt[i].resp));
        chk($sformatf("v%0d_ctrl_wr", i), 32'(p), 32'(vt[i].pulse));
      end else begin
        rd(vt[i].addr, d, r);
        chk($sformatf("v%0d_rresp", i), 32'(r), 32'(vt[i].resp));
        chk($sformatf("v%0d_rdata", i), d, vt[i].rdata);
      end
    end

    // AW first, W three cycles later, partial strobe on reg1 (0xC0550001)
    @(negedge sys_clk);
    s_axil.awvalid = 1'b1; s_axil.awaddr = 32'h004;
    @(negedge sys_clk);
    s_axil.awvalid = 1'b0;
    chk("aw1st_awready", 32'(s_axil.awready), 0);
    chk("aw1st_wready",  32'(s_axil.wready), 1);
    chk("aw1st_bvalid",  32'(s_axil.bvalid), 0);
    @(negedge sys_clk); @(negedge sys_clk);
    chk("aw1st_nopulse", 32'(ctrl_wr), 0);
    s_axil.wvalid = 1'b1; s_axil.wdata = 32'hA5A51234; s_axil.wstrb = 4'b0011;
    @(negedge sys_clk);
    s_axil.wvalid = 1'b0;
    chk("aw1st_bvalid1", 32'(s_axil.bvalid), 1);
    chk("aw1st_bresp",   32'(s_axil.bresp), 0);
    chk("aw1st_pulse",   32'(ctrl_wr), 32'h02);
    chk("aw1st_reg1",    creg(1), 32'hC0551234);
    @(negedge sys_clk);
    chk("aw1st_pulse_once", 32'(ctrl_wr), 0);
    chk("aw1st_bdone",      32'(s_axil.bvalid), 0);

    // W first, then AW, B held off 5 cycles while a second write waits
    s_axil.bready = 1'b0;
    s_axil.wvalid = 1'b1; s_axil.wdata = 32'h0000BEEF; s_axil.wstrb = 4'hF;
    @(negedge sys_clk);
    s_axil.wvalid = 1'b0;
    chk("w1st_wready", 32'(s_axil.wready), 0);
    s_axil.awvalid = 1'b1; s_axil.awaddr = 32'h00C;
    @(negedge sys_clk);
    chk("w1st_bvalid", 32'(s_axil.bvalid), 1);
    chk("w1st_reg3",   creg(3), 32'h0000BEEF);
    chk("w1st_pulse",  32'(ctrl_wr), 32'h08);
    s_axil.awaddr = 32'h014;
    s_axil.wvalid = 1'b1; s_axil.wdata = 32'h00000077;
    for (int c = 0; c < 5; c++) begin
      @(negedge sys_clk);
      chk($sformatf("hold%0d_bvalid", c), 32'(s_axil.bvalid), 1);
      chk($sformatf("hold%0d_awready", c), 32'(s_axil.awready), 0);
      chk($sformatf("hold%0d_wready", c), 32'(s_axil.wready), 0);
      chk($sformatf("hold%0d_reg5", c), creg(5), 32'hC0DE0005);
    end
    s_axil.bready = 1'b1;
    @(negedge sys_clk);
    chk("hold_bdone",   32'(s_axil.bvalid), 0);
    chk("hold_awready", 32'(s_axil.awready), 1);
    @(negedge sys_clk);
    s_axil.awvalid = 1'b0; s_axil.wvalid = 1'b0;
    chk("second_bvalid", 32'(s_axil.bvalid), 1);
    chk("second_reg5",   creg(5), 32'h00000077);

    // Same-edge AR and AW+W on reg2 (holds 0x11)
    @(negedge sys_clk);
    s_axil.arvalid = 1'b1; s_axil.araddr = 32'h008;
    s_axil.awvalid = 1'b1; s_axil.awaddr = 32'h008;
    s_axil.wvalid  = 1'b1; s_axil.wdata  = 32'h00000022; s_axil.wstrb = 4'hF;
    @(negedge sys_clk);
    s_axil.arvalid = 1'b0; s_axil.awvalid = 1'b0; s_axil.wvalid = 1'b0;
    chk("same_rvalid", 32'(s_axil.rvalid), 1);
    chk("same_rdata",  s_axil.rdata, 32'h00000011);
    chk("same_bvalid", 32'(s_axil.bvalid), 1);
    rd(32'h008, d, r);
    chk("same_reread", d, 32'h00000022);

`ifdef AXIL_REG_STICKY_EN
    @(negedge sys_clk);
    stat_in = '0;
    rd(32'h020, d, r);
    chk("sticky_old", d, 32'h5A000000);
    rd(32'h020, d, r);
    chk("sticky_cleared", d, 0);
    @(negedge sys_clk); stat_in[0] = 1'b1;
    @(negedge sys_clk); stat_in[0] = 1'b0;
    rd(32'h020, d, r);
    chk("sticky_pulse", d, 1);
    chk("sticky_rresp", 32'(r), 0);
    rd(32'h020, d, r);
    chk("sticky_clr", d, 0);
    @(negedge sys_clk); stat_in[0] = 1'b1;
    @(negedge sys_clk); stat_in[0] = 1'b0;
    @(negedge sys_clk);
    s_axil.arvalid = 1'b1; s_axil.araddr = 32'h020; stat_in[0] = 1'b1;
    @(negedge sys_clk);
    s_axil.arvalid = 1'b0; stat_in[0] = 1'b0;
    chk("sticky_coinc_rdata", s_axil.rdata, 1);
    rd(32'h020, d, r);
    chk("sticky_coinc_kept", d, 1);
    rd(32'h020, d, r);
    chk("sticky_coinc_clr", d, 0);
`else
    @(negedge sys_clk);
    stat_in[63:32] = 32'h000000F0;
    rd(32'h024, d, r);
    chk("live_a", d, 32'h000000F0);
    stat_in[63:32] = 32'h0000000F;
    rd(32'h024, d, r);
    chk("live_b", d, 32'h0000000F);
    chk("live_rresp", 32'(r), 0);
`endif

    @(negedge sys_clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
